// File: rtl/rd_regfile_pkg.sv
// Shared CPU package: register-file geometry, the hardwired zero index,
// and the writeback bundle carried by the pipeline registers into the RF.
package rd_regfile_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;
  localparam int ZERO_REG  = 0;

  // Field widths of the rd writeback bundle (memory-stage -> register file)
  localparam int RD_WB_WE_W   = 1;
  localparam int RD_WB_ADDR_W = RF_ADDR_W;
  localparam int RD_WB_DATA_W = RF_DATA_W;

  typedef struct packed {
    logic [RD_WB_WE_W-1:0]   we;
    logic [RD_WB_ADDR_W-1:0] addr;
    logic [RD_WB_DATA_W-1:0] data;
  } rd_wb_t;

  localparam int RD_WB_W = RD_WB_WE_W + RD_WB_ADDR_W + RD_WB_DATA_W;

endpackage

// File: rtl/rd_regfile_read_port.sv
// One registered read port: forces x0 to zero, forwards a same-cycle
// writeback to the same index, and flags the result valid for one cycle.
module rf_read_port
  import rd_regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rs_re,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_stored,
  output logic [DATA_W-1:0] rs_data,
  output logic              rs_valid
);

  logic              w_isZero;
  logic              w_bypass;
  logic [DATA_W-1:0] w_nextData;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Select the value to capture: zero register, forwarded writeback, or storage
  always_comb begin
    w_isZero   = (rs_addr == ADDR_W'(ZERO_REG));
    w_bypass   = rd_we && (rd_addr == rs_addr);
    w_nextData = rs_stored;
    if (w_isZero) begin
      w_nextData = '0;
    end else if (w_bypass) begin
      w_nextData = rd_data;
    end
  end

  // Capture the read result on request; hold it otherwise, valid tracks the request
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= rs_re;
      if (rs_re) begin
        r_data <= w_nextData;
      end
    end
  end

  assign rs_data  = r_data;
  assign rs_valid = r_valid;

endmodule

// File: rtl/rd_regfile.sv
// Integer register file: one writeback port, two registered read ports with
// write-to-read bypass; x0 is hardwired to zero.
module rd_regfile
  import rd_regfile_pkg::*;
#(
  parameter int DATA_W = RF_DATA_W,
  parameter int ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_we,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rs1_re,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic              rs2_re,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs1_data,
  output logic              rs1_valid,
  output logic [DATA_W-1:0] rs2_data,
  output logic              rs2_valid
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [DEPTH];
  logic [DATA_W-1:0] w_rs1Stored;
  logic [DATA_W-1:0] w_rs2Stored;

  // Storage update: reset clears every entry, writes to x0 are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rd_we && (rd_addr != ADDR_W'(ZERO_REG))) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  assign w_rs1Stored = r_regs[rs1_addr];
  assign w_rs2Stored = r_regs[rs2_addr];

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rs1Port (
    .clk      (clk),
    .rst      (rst),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs_re    (rs1_re),
    .rs_addr  (rs1_addr),
    .rs_stored(w_rs1Stored),
    .rs_data  (rs1_data),
    .rs_valid (rs1_valid)
  );

  rf_read_port #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_rs2Port (
    .clk      (clk),
    .rst      (rst),
    .rd_we    (rd_we),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rs_re    (rs2_re),
    .rs_addr  (rs2_addr),
    .rs_stored(w_rs2Stored),
    .rs_data  (rs2_data),
    .rs_valid (rs2_valid)
  );

endmodule

// File: doc/rd_regfile.md
RD_REGFILE -- requirements
Module: rd_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register data width.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register index width (2**ADDR_W entries).
REQ-003 The block SHALL have port clk  input  1  clock; all state updates on posedge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port rd_we  input  1  writeback enable from the memory-stage register.
REQ-006 The block SHALL have port rd_addr  input  ADDR_W  writeback destination index.
REQ-007 The block SHALL have port rd_data  input  DATA_W  writeback value.
REQ-008 The block SHALL have ports rs1_re / rs2_re  input  1  read request, port 1 / port 2.
REQ-009 The block SHALL have ports rs1_addr / rs2_addr  input  ADDR_W  read source index.
REQ-010 The block SHALL have ports rs1_data / rs2_data  output  DATA_W  registered read result.
REQ-011 The block SHALL have ports rs1_valid / rs2_valid  output  1  high for the one cycle after an accepted read.

Function
REQ-012 Write: on posedge with rst=0, rd_we=1, rd_addr!=0 -> entry[rd_addr] <= rd_data; no other entry changes.
REQ-013 Writes to index 0 SHALL be discarded; entry 0 SHALL always read as 0.
REQ-014 Read latency SHALL be exactly 1 cycle: rsN_re sampled at edge k -> rsN_data/rsN_valid updated at edge k, visible in cycle k+1.
REQ-015 Read value: rsN_addr==0 -> 0; else rd_we=1 and rd_addr==rsN_addr in the same cycle -> rd_data (write-to-read bypass); else entry[rsN_addr].
REQ-016 rsN_re=0 at an edge -> rsN_data SHALL hold its previous value, rsN_valid <= 0.
REQ-017 rsN_valid SHALL equal rsN_re delayed one cycle (no back-pressure; every request accepted).
REQ-018 Both ports same index same cycle -> both SHALL return identical values, including the bypass case.
REQ-019 Read and write to different indices same cycle -> read returns old stored value of the read index, write proceeds.
REQ-020 Write to index 0 with simultaneous read of index 0 -> read returns 0; no bypass.
REQ-021 Back-to-back writes to one index -> last write wins; a read in the cycle of the second write returns the second value via bypass.
REQ-022 Address inputs SHALL be used unsigned at full ADDR_W width; no aliasing.

Reset
REQ-023 rst=1 at an edge SHALL clear all entries to 0, rs1_data=rs2_data=0, rs1_valid=rs2_valid=0.
REQ-024 rst SHALL dominate: a write or read presented in a reset cycle SHALL have no effect.
REQ-025 The first cycle after rst deasserts SHALL accept writes and reads normally.
REQ-026 Reset asserted mid-stream (e.g. between a write and its dependent read) -> the dependent read SHALL return 0.

Structure
REQ-027 DATA_W/ADDR_W defaults and constant ZERO_REG=0 SHALL live in the shared CPU package, alongside the rd writeback bundle field widths used by the pipeline registers.
REQ-028 Storage SHALL be one register array plus two identical read-port instances of sub-module rf_read_port (address-zero check, bypass compare, output register, valid flag).
REQ-029 Bypass logic SHALL be combinational from rd_we/rd_addr/rd_data into the read-port register; no extra pipeline stage.

Verification
REQ-030 Reset clear: write 0xDEADBEEF to x5, assert rst one cycle, read x5 -> rs1_data=0, rs1_valid=1 one cycle later.
REQ-031 Basic RW: write 0x12345678 to x7 at edge k; read x7 on port 2 at edge k+1 -> rs2_data=0x12345678 in cycle k+2.
REQ-032 Bypass: same cycle rd_we=1, rd_addr=9, rd_data=0xA5A5A5A5, rs1_addr=rs2_addr=9, both re=1 -> both data=0xA5A5A5A5, both valid=1 next cycle.
REQ-033 x0: rd_we=1, rd_addr=0, rd_data=0xFFFFFFFF with rs1 reading x0 -> rs1_data=0; later read of x0 -> 0.
REQ-034 Hold: read x3 (=0x11), then rs1_re=0 for 3 cycles while writing x3=0x22 -> rs1_data stays 0x11, rs1_valid=0; next read -> 0x22.
REQ-035 Random: 10k cycles random writes/reads vs. reference model, including reset pulses -> zero mismatches.
